// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcode, field and state definitions for the multicycle core
package mips_pkg;

    localparam int OP_HI = 15;
    localparam int OP_LO = 12;
    localparam int RA_HI = 11;
    localparam int RA_LO = 8;
    localparam int RB_HI = 7;
    localparam int RB_LO = 4;
    localparam int RC_HI = 3;
    localparam int RC_LO = 0;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_SLT  = 4'h4;
    localparam logic [3:0] OP_ADDI = 4'h5;
    localparam logic [3:0] OP_LW   = 4'h6;
    localparam logic [3:0] OP_SW   = 4'h7;
    localparam logic [3:0] OP_BNE  = 4'h8;
    localparam logic [3:0] OP_BEQ  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    // Register-register ops write rc; everything else that writes uses rb.
    function automatic logic op_is_rrr(input logic [3:0] op);
        return op <= OP_SLT;
    endfunction

endpackage

// File: rtl/mips_regfile.sv
// rtl/mips_regfile.sv - 16-entry register file, two read ports, debug port, one write port
module mips_regfile
    import mips_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              clear,
    input  logic [3:0]        rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [3:0]        rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic [3:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              wr_en,
    input  logic [3:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] regs [16];

    // Storage: cleared asynchronously, r0 never written so it always reads zero.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != 4'd0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rd_data_a = (rd_addr_a == 4'd0) ? '0 : regs[rd_addr_a];
    assign rd_data_b = (rd_addr_b == 4'd0) ? '0 : regs[rd_addr_b];
    assign dbg_data  = (dbg_addr  == 4'd0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/mips_multicycle.sv
// rtl/mips_multicycle.sv - 16-bit-instruction multicycle core with handshaked instruction/data ports
module mips_multicycle
    import mips_pkg::*;
#(
    parameter int                 DATA_W   = 16,
    parameter int                 ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              clear,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    input  logic              imem_ack,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              retire,
    output logic              illegal,
    input  logic [3:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    state_t            state, state_next;
    logic [15:0]       ir;
    logic [DATA_W-1:0] opa, opb, res, alu_out;
    logic [ADDR_W-1:0] mar, pc_next, pc_inc, pc_br;
    logic [DATA_W-1:0] rd_a, rd_b, imm;
    logic [ADDR_W-1:0] imm_a;
    logic [3:0]        op, ra, rb, rc, wr_addr;
    logic              fetch_req, taken, rf_we;

    assign op = ir[OP_HI:OP_LO];
    assign ra = ir[RA_HI:RA_LO];
    assign rb = ir[RB_HI:RB_LO];
    assign rc = ir[RC_HI:RC_LO];

    assign imm     = {{(DATA_W-4){rc[3]}}, rc};
    assign imm_a   = {{(ADDR_W-4){rc[3]}}, rc};
    assign pc_inc  = pc + ADDR_W'(1);
    assign pc_br   = pc_inc + imm_a;
    assign taken   = ((op == OP_BNE) && (opa != opb)) || ((op == OP_BEQ) && (opa == opb));
    assign wr_addr = op_is_rrr(op) ? rc : rb;

    mips_regfile #(.DATA_W(DATA_W)) u_regfile (
        .clk       (clk),
        .clear     (clear),
        .rd_addr_a (ra),
        .rd_data_a (rd_a),
        .rd_addr_b (rb),
        .rd_data_b (rd_b),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .wr_en     (rf_we),
        .wr_addr   (wr_addr),
        .wr_data   (res)
    );

    // ALU: register ops, otherwise ra+imm (ADDI result and LW/SW address).
    always_comb begin
        alu_out = opa + imm;
        case (op)
            OP_ADD:  alu_out = opa + opb;
            OP_SUB:  alu_out = opa - opb;
            OP_AND:  alu_out = opa & opb;
            OP_OR:   alu_out = opa | opb;
            OP_SLT:  alu_out = DATA_W'($signed(opa) < $signed(opb));
            default: alu_out = opa + imm;
        endcase
    end

    // Next-state, handshake requests, retire/illegal pulses and next pc.
    always_comb begin
        state_next = state;
        fetch_req  = 1'b0;
        dmem_req   = 1'b0;
        retire     = 1'b0;
        illegal    = 1'b0;
        rf_we      = 1'b0;
        pc_next    = pc;
        case (state)
            S_FETCH: begin
                fetch_req = 1'b1;
                if (imem_ack) state_next = S_DECODE;
            end
            S_DECODE: state_next = S_EXEC;
            S_EXEC: begin
                if (op_is_rrr(op) || (op == OP_ADDI)) begin
                    state_next = S_WB;
                end else if ((op == OP_LW) || (op == OP_SW)) begin
                    state_next = S_MEM;
                end else if ((op == OP_BNE) || (op == OP_BEQ)) begin
                    state_next = S_FETCH;
                    retire     = 1'b1;
                    pc_next    = taken ? pc_br : pc_inc;
                end else if (op == OP_HALT) begin
                    state_next = S_HALT;
                    retire     = 1'b1;
                    pc_next    = pc_inc;
                end else begin
                    state_next = S_FETCH;
                    retire     = 1'b1;
                    illegal    = 1'b1;
                    pc_next    = pc_inc;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                if (dmem_ack) begin
                    if (op == OP_LW) begin
                        state_next = S_WB;
                    end else begin
                        state_next = S_FETCH;
                        retire     = 1'b1;
                        pc_next    = pc_inc;
                    end
                end
            end
            S_WB: begin
                rf_we      = 1'b1;
                retire     = 1'b1;
                pc_next    = pc_inc;
                state_next = S_FETCH;
            end
            default: state_next = S_HALT;
        endcase
    end

    // State, pc and datapath registers; clear wins over any pending handshake.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state <= S_FETCH;
            pc    <= RESET_PC;
            ir    <= '0;
            opa   <= '0;
            opb   <= '0;
            res   <= '0;
            mar   <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if ((state == S_FETCH) && imem_ack) ir <= imem_rdata;
            if (state == S_DECODE) begin
                opa <= rd_a;
                opb <= rd_b;
            end
            if (state == S_EXEC) begin
                res <= alu_out;
                mar <= alu_out[ADDR_W-1:0];
            end
            if ((state == S_MEM) && dmem_ack && (op == OP_LW)) res <= dmem_rdata;
        end
    end

    // FETCH is the reset state, so the fetch request is masked while clear is held.
    assign imem_req   = fetch_req && !clear;
    assign imem_addr  = pc;
    assign dmem_we    = (op == OP_SW);
    assign dmem_addr  = mar;
    assign dmem_wdata = opb;
    assign halted     = (state == S_HALT);

endmodule

// File: tb/tb_mips_multicycle.sv
// tb/tb_mips_multicycle.sv - directed self-checking bench for mips_multicycle
module tb_mips_multicycle;

    logic        clk = 1'b0;
    logic        clear;
    logic        imem_req, imem_ack;
    logic [15:0] imem_addr, imem_rdata;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [15:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [15:0] pc;
    logic        halted, retire, illegal;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;

    int checks = 0;
    int errors = 0;

    logic [15:0] imem [65536];
    logic [15:0] dmem [16];
    int          dwait = 0;
    int          dcnt = 0;
    logic [15:0] st_addr, st_data;

    int cyc = 0;
    int drun = 0;
    int ill_cnt = 0;
    int ret_q[$];
    int fetch_q[$];
    int dreq_q[$];

    always #5 clk = ~clk;

    mips_multicycle #(.DATA_W(16), .ADDR_W(16), .RESET_PC(16'h0000)) dut (
        .clk        (clk),
        .clear      (clear),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ack   (imem_ack),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .pc         (pc),
        .halted     (halted),
        .retire     (retire),
        .illegal    (illegal),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    function automatic logic [15:0] enc(input logic [3:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rc);
        return {op, ra, rb, rc};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory responder: imem zero-wait, dmem acks after dwait extra cycles.
    initial begin
        imem_ack   = 1'b0;
        imem_rdata = '0;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        st_addr    = '0;
        st_data    = '0;
        for (int i = 0; i < 16; i++) dmem[i] = '0;
        dmem[3] = 16'h8000;
        forever begin
            @(posedge clk);
            #2;
            imem_ack   = imem_req;
            imem_rdata = imem[imem_addr];
            if (dmem_req) begin
                dmem_ack = (dcnt >= dwait);
                dcnt     = dmem_ack ? 0 : dcnt + 1;
                if (dmem_ack && dmem_we) begin
                    dmem[dmem_addr[3:0]] = dmem_wdata;
                    st_addr = dmem_addr;
                    st_data = dmem_wdata;
                end
                dmem_rdata = dmem[dmem_addr[3:0]];
            end else begin
                dmem_ack = 1'b0;
                dcnt     = 0;
            end
        end
    end

    // Monitor: retire times, fetch addresses, dmem_req run lengths, illegal pulses.
    initial begin
        forever begin
            @(negedge clk);
            if (clear) begin
                cyc = 0; drun = 0; ill_cnt = 0;
                ret_q.delete(); fetch_q.delete(); dreq_q.delete();
            end else begin
                cyc++;
                if (retire) ret_q.push_back(cyc);
                if (illegal) ill_cnt++;
                if (imem_req && imem_ack) fetch_q.push_back(int'(imem_addr));
                if (dmem_req) drun++;
                else if (drun > 0) begin
                    dreq_q.push_back(drun);
                    drun = 0;
                end
            end
        end
    end

    task automatic hold_clear();
        @(posedge clk);
        #3 clear = 1'b1;
        for (int a = 0; a < 65536; a++) imem[a] = 16'h0000;
    endtask

    task automatic release_clear();
        @(posedge clk);
        @(posedge clk);
        #1 clear = 1'b0;
    endtask

    task automatic run_to_halt(input string tag);
        for (int i = 0; i < 400 && !halted; i++) @(negedge clk);
        check({tag, "_halt"}, halted, 1);
    endtask

    task automatic reg_is(input string tag, input logic [3:0] r, input logic [15:0] exp);
        dbg_addr = r;
        #1;
        check(tag, dbg_data, exp);
    endtask

    initial begin
        clear    = 1'b1;
        dbg_addr = '0;
        for (int a = 0; a < 65536; a++) imem[a] = 16'h0000;

        #12;
        check("rst_imem_req", imem_req, 0);
        check("rst_dmem_req", dmem_req, 0);
        check("rst_pc", pc, 16'h0000);
        check("rst_halted", halted, 0);
        check("rst_retire", retire, 0);

        // ADDI/ADDI/ADD chain, retire spacing
        imem[0] = enc(4'h5, 4'd0, 4'd1, 4'd5);
        imem[1] = enc(4'h5, 4'd0, 4'd2, 4'hD);
        imem[2] = enc(4'h0, 4'd1, 4'd2, 4'd3);
        imem[3] = enc(4'hF, 4'd0, 4'd0, 4'd0);
        @(posedge clk);
        #1 clear = 1'b0;
        #2 check("first_fetch_req", imem_req, 1);
        check("first_fetch_addr", imem_addr, 16'h0000);
        run_to_halt("t1");
        reg_is("t1_r1", 4'd1, 16'h0005);
        reg_is("t1_r2", 4'd2, 16'hFFFD);
        reg_is("t1_r3", 4'd3, 16'h0002);
        check("t1_gap01", ret_q[1] - ret_q[0], 4);
        check("t1_gap12", ret_q[2] - ret_q[1], 4);
        check("t1_retires", ret_q.size(), 4);

        // SW then LW with dmem ack delayed 3 cycles
        hold_clear();
        dwait = 3;
        imem[0] = enc(4'h5, 4'd0, 4'd1, 4'd5);
        imem[1] = enc(4'h7, 4'd0, 4'd1, 4'd2);
        imem[2] = enc(4'h6, 4'd0, 4'd4, 4'd2);
        imem[3] = enc(4'hF, 4'd0, 4'd0, 4'd0);
        release_clear();
        run_to_halt("t2");
        check("t2_st_addr", st_addr, 16'h0002);
        check("t2_st_data", st_data, 16'h0005);
        reg_is("t2_r4", 4'd4, 16'h0005);
        check("t2_sw_req_len", dreq_q[0], 4);
        check("t2_lw_req_len", dreq_q[1], 4);
        check("t2_sw_cycles", ret_q[1] - ret_q[0], 7);
        check("t2_lw_cycles", ret_q[2] - ret_q[1], 8);
        dwait = 0;

        // BNE taken at pc=10 (reached via BEQ taken)
        hold_clear();
        imem[0]  = enc(4'h5, 4'd0, 4'd1, 4'd1);
        imem[1]  = enc(4'h5, 4'd0, 4'd2, 4'd2);
        imem[2]  = enc(4'h9, 4'd0, 4'd0, 4'd7);
        imem[10] = enc(4'h8, 4'd1, 4'd2, 4'hE);
        imem[9]  = enc(4'hF, 4'd0, 4'd0, 4'd0);
        imem[11] = enc(4'hF, 4'd0, 4'd0, 4'd0);
        release_clear();
        run_to_halt("t3a");
        check("t3a_beq_target", fetch_q[3], 10);
        check("t3a_bne_taken", fetch_q[4], 9);

        // BNE not taken at pc=10
        hold_clear();
        imem[0]  = enc(4'h5, 4'd0, 4'd1, 4'd1);
        imem[1]  = enc(4'h5, 4'd0, 4'd2, 4'd1);
        imem[2]  = enc(4'h9, 4'd0, 4'd0, 4'd7);
        imem[10] = enc(4'h8, 4'd1, 4'd2, 4'hE);
        imem[9]  = enc(4'hF, 4'd0, 4'd0, 4'd0);
        imem[11] = enc(4'hF, 4'd0, 4'd0, 4'd0);
        release_clear();
        run_to_halt("t3b");
        check("t3b_bne_fall", fetch_q[4], 11);

        // pc wrap from 0xFFFF and signed SLT
        hold_clear();
        imem[0]      = enc(4'h8, 4'd5, 4'd0, 4'd3);
        imem[1]      = enc(4'h5, 4'd0, 4'd5, 4'd1);
        imem[2]      = enc(4'h6, 4'd0, 4'd6, 4'd3);
        imem[3]      = enc(4'h9, 4'd0, 4'd0, 4'hB);
        imem[16'hFFFF] = enc(4'h4, 4'd6, 4'd5, 4'd7);
        imem[4]      = enc(4'hF, 4'd0, 4'd0, 4'd0);
        release_clear();
        run_to_halt("t4");
        check("t4_fetch_ffff", fetch_q[4], 16'hFFFF);
        check("t4_wrap", fetch_q[5], 0);
        check("t4_bne_back", fetch_q[6], 4);
        reg_is("t4_r6", 4'd6, 16'h8000);
        reg_is("t4_slt", 4'd7, 16'h0001);

        // undefined opcode then HALT
        hold_clear();
        imem[0] = 16'hC000;
        imem[1] = enc(4'hF, 4'd0, 4'd0, 4'd0);
        release_clear();
        run_to_halt("t5");
        check("t5_illegal", ill_cnt, 1);
        check("t5_retires", ret_q.size(), 2);
        begin
            int req_seen = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (imem_req) req_seen++;
            end
            check("t5_no_fetch", req_seen, 0);
        end
        check("t5_still_halted", halted, 1);

        // clear while a store is pending
        hold_clear();
        dwait = 50;
        imem[0] = enc(4'h5, 4'd0, 4'd1, 4'd5);
        imem[1] = 16'h0000;
        imem[2] = enc(4'h7, 4'd0, 4'd1, 4'd1);
        release_clear();
        for (int i = 0; i < 40 && !dmem_req; i++) @(negedge clk);
        check("t6_dreq_up", dmem_req, 1);
        check("t6_pc_before", pc, 16'h0002);
        @(posedge clk);
        #3 clear = 1'b1;
        #1;
        check("t6_dreq_drop", dmem_req, 0);
        check("t6_pc_reset", pc, 16'h0000);
        check("t6_no_fetch", imem_req, 0);
        reg_is("t6_r1_cleared", 4'd1, 16'h0000);
        dwait = 0;
        @(posedge clk);
        #1 clear = 1'b0;
        #2;
        check("t6_fetch_req", imem_req, 1);
        check("t6_fetch_addr", imem_addr, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
